// File: rtl/mp_step_ctrl_if.sv
// Board-side manual-clock bundle between the validation top and mp_step_ctrl.
// The master drives the raw board and core inputs; the slave returns step and phase status.
interface mp_step_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             key_in;
  logic             manual;
  logic             halt;
  logic             step;
  logic [1:0]       phase;
  logic [3:0]       phase_oh;
  logic             instr_done;
  logic [CNT_W-1:0] instr_count;
  logic             key_level;

  modport master (
    output key_in,
    output manual,
    output halt,
    input  step,
    input  phase,
    input  phase_oh,
    input  instr_done,
    input  instr_count,
    input  key_level
  );

  modport slave (
    input  key_in,
    input  manual,
    input  halt,
    output step,
    output phase,
    output phase_oh,
    output instr_done,
    output instr_count,
    output key_level
  );
endinterface

// File: rtl/mp_step_ctrl.sv
// Manual/auto step controller: debounces KEY0 into single-cycle step pulses, sequences
// the FD -> EX -> RWB -> IF phases and counts retired instructions.
module mp_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int AUTO_DIV        = 8,
  parameter int CNT_W           = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  mp_step_ctrl_if.slave bus
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DIV_W = $clog2(AUTO_DIV);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(AUTO_DIV - 1);

  localparam logic [1:0] PH_FD  = 2'd0;
  localparam logic [1:0] PH_EX  = 2'd1;
  localparam logic [1:0] PH_RWB = 2'd2;
  localparam logic [1:0] PH_IF  = 2'd3;

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             key_level_q, key_level_d;
  logic             key_prev_q, key_prev_d;
  logic [1:0]       settle_q, settle_d;
  logic             armed_q, armed_d;
  logic             manual_prev_q, manual_prev_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             step_q, step_d;
  logic             instr_done_q, instr_done_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic [1:0]       phase_q, phase_d;
  logic [3:0]       phase_oh_q, phase_oh_d;

  logic key_rise;
  logic man_fire;
  logic auto_fire;
  logic candidate;

  // Two-flop synchroniser followed by a stability counter; the counter is
  // compared against DEBOUNCE_CYCLES-1 so the level flips on the Nth mismatch.
  always_comb begin
    s1_d        = bus.key_in;
    s2_d        = s1_q;
    db_cnt_d    = '0;
    key_level_d = key_level_q;
    if (s2_q != key_level_q) begin
      if (db_cnt_q == DB_LAST) begin
        key_level_d = s2_q;
        db_cnt_d    = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // A press only counts once the key has been seen released after reset, so a
  // key held through reset must be let go before it can step again.
  always_comb begin
    key_prev_d = key_level_q;
    settle_d   = {settle_q[0], 1'b1};
    armed_d    = armed_q | (settle_q[1] & ~s2_q & ~key_level_q);
    key_rise   = key_level_q & ~key_prev_q;
    man_fire   = bus.manual & armed_q & key_rise;
  end

  // The divider is held clear in manual mode and on the first auto clock, so
  // the first auto step lands exactly AUTO_DIV clocks after manual drops.
  always_comb begin
    manual_prev_d = bus.manual;
    auto_fire     = 1'b0;
    div_d         = '0;
    if (!bus.manual && !manual_prev_q) begin
      if (div_q == DIV_LAST) begin
        auto_fire = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_comb begin
    candidate     = bus.manual ? man_fire : auto_fire;
    step_d        = candidate & ~step_q & ~((phase_q == PH_FD) & bus.halt);
    instr_done_d  = step_d & (phase_q == PH_IF);
    instr_count_d = instr_count_q;
    if (instr_done_d) begin
      instr_count_d = instr_count_q + 1'b1;
    end
  end

  // Phase advances on the clock after the step pulse, so the pulse and the
  // halt gate always see the phase being left.
  always_comb begin
    phase_d = phase_q;
    if (step_q) begin
      case (phase_q)
        PH_FD:   phase_d = PH_EX;
        PH_EX:   phase_d = PH_RWB;
        PH_RWB:  phase_d = PH_IF;
        default: phase_d = PH_FD;
      endcase
    end
    case (phase_d)
      PH_FD:   phase_oh_d = 4'b0001;
      PH_EX:   phase_oh_d = 4'b0010;
      PH_RWB:  phase_oh_d = 4'b0100;
      default: phase_oh_d = 4'b1000;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      db_cnt_q      <= '0;
      key_level_q   <= 1'b0;
      key_prev_q    <= 1'b0;
      settle_q      <= 2'b00;
      armed_q       <= 1'b0;
      manual_prev_q <= 1'b0;
      div_q         <= '0;
      step_q        <= 1'b0;
      instr_done_q  <= 1'b0;
      instr_count_q <= '0;
      phase_q       <= PH_FD;
      phase_oh_q    <= 4'b0001;
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      db_cnt_q      <= db_cnt_d;
      key_level_q   <= key_level_d;
      key_prev_q    <= key_prev_d;
      settle_q      <= settle_d;
      armed_q       <= armed_d;
      manual_prev_q <= manual_prev_d;
      div_q         <= div_d;
      step_q        <= step_d;
      instr_done_q  <= instr_done_d;
      instr_count_q <= instr_count_d;
      phase_q       <= phase_d;
      phase_oh_q    <= phase_oh_d;
    end
  end

  assign bus.step        = step_q;
  assign bus.phase       = phase_q;
  assign bus.phase_oh    = phase_oh_q;
  assign bus.instr_done  = instr_done_q;
  assign bus.instr_count = instr_count_q;
  assign bus.key_level   = key_level_q;

endmodule

// File: tb/tb_mp_step_ctrl.sv
// Directed bench for mp_step_ctrl: a vector table for steady-state behaviour plus
// hand-written sequences for latency, bounce, auto spacing, halt, reset and wrap.
module tb_mp_step_ctrl;

  logic clk;
  logic reset_n;

  mp_step_ctrl_if #(.CNT_W(16)) bus ();

  mp_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .AUTO_DIV(8),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        key;
    logic        manual;
    logic        halt;
    int          cycles;
    int          exp_steps;
    int          exp_done;
    logic [1:0]  exp_phase;
    logic [3:0]  exp_oh;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs [16];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int steps = 0;
  int dones = 0;
  int consec = 0;
  int last_step_cyc = 0;
  logic prev_step = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.step) begin
      steps++;
      last_step_cyc = cyc;
      if (prev_step) consec++;
    end
    if (bus.instr_done) dones++;
    prev_step = bus.step;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clearCounts();
    steps  = 0;
    dones  = 0;
    consec = 0;
  endtask

  task automatic doReset();
    reset_n     = 1'b0;
    bus.key_in  = 1'b0;
    bus.manual  = 1'b1;
    bus.halt    = 1'b0;
    run(3);
    reset_n = 1'b1;
    run(4);
    clearCounts();
  endtask

  task automatic press(input int hi, input int lo);
    bus.key_in = 1'b1;
    run(hi);
    bus.key_in = 1'b0;
    run(lo);
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.key_in = v.key;
    bus.manual = v.manual;
    bus.halt   = v.halt;
    clearCounts();
    run(v.cycles);
  endtask

  function automatic vec_t mk(input logic key, input logic manual, input logic halt,
                              input int cycles, input int st, input int dn,
                              input logic [1:0] ph, input logic [3:0] oh,
                              input logic [15:0] cnt);
    vec_t v;
    v.key = key; v.manual = manual; v.halt = halt; v.cycles = cycles;
    v.exp_steps = st; v.exp_done = dn; v.exp_phase = ph; v.exp_oh = oh;
    v.exp_count = cnt;
    return v;
  endfunction

  initial begin
    int start;
    int first;
    int prev;
    int n;
    int bad;
    int lat;
    int waited;
    logic [15:0] c0;

    vecs[0]  = mk(0, 1, 0, 10, 0, 0, 2'd0, 4'b0001, 16'd0);
    vecs[1]  = mk(1, 1, 0, 10, 1, 0, 2'd1, 4'b0010, 16'd0);
    vecs[2]  = mk(0, 1, 0, 10, 0, 0, 2'd1, 4'b0010, 16'd0);
    vecs[3]  = mk(1, 1, 0, 10, 1, 0, 2'd2, 4'b0100, 16'd0);
    vecs[4]  = mk(0, 1, 0, 10, 0, 0, 2'd2, 4'b0100, 16'd0);
    vecs[5]  = mk(1, 1, 0, 10, 1, 0, 2'd3, 4'b1000, 16'd0);
    vecs[6]  = mk(0, 1, 0, 10, 0, 0, 2'd3, 4'b1000, 16'd0);
    vecs[7]  = mk(1, 1, 0, 10, 1, 1, 2'd0, 4'b0001, 16'd1);
    vecs[8]  = mk(0, 1, 0, 10, 0, 0, 2'd0, 4'b0001, 16'd1);
    vecs[9]  = mk(1, 1, 1, 10, 0, 0, 2'd0, 4'b0001, 16'd1);
    vecs[10] = mk(0, 1, 1, 10, 0, 0, 2'd0, 4'b0001, 16'd1);
    vecs[11] = mk(0, 0, 0, 16, 1, 0, 2'd1, 4'b0010, 16'd1);
    vecs[12] = mk(1, 0, 0, 16, 2, 0, 2'd3, 4'b1000, 16'd1);
    vecs[13] = mk(0, 0, 0, 8,  1, 1, 2'd0, 4'b0001, 16'd2);
    vecs[14] = mk(0, 1, 0, 10, 0, 0, 2'd0, 4'b0001, 16'd2);
    vecs[15] = mk(1, 1, 0, 10, 1, 0, 2'd1, 4'b0010, 16'd2);

    // Reset values while reset is held.
    reset_n    = 1'b0;
    bus.key_in = 1'b0;
    bus.manual = 1'b1;
    bus.halt   = 1'b0;
    run(3);
    checkOutput("rst_step", bus.step, 0);
    checkOutput("rst_phase", bus.phase, 0);
    checkOutput("rst_phase_oh", bus.phase_oh, 4'b0001);
    checkOutput("rst_instr_done", bus.instr_done, 0);
    checkOutput("rst_count", bus.instr_count, 0);
    checkOutput("rst_key_level", bus.key_level, 0);

    // Idle after reset.
    reset_n = 1'b1;
    clearCounts();
    run(50);
    checkOutput("idle_steps", steps, 0);
    checkOutput("idle_phase", bus.phase, 0);
    checkOutput("idle_phase_oh", bus.phase_oh, 4'b0001);
    checkOutput("idle_count", bus.instr_count, 0);

    // Held key: single step on edge 7 after the first high sample.
    clearCounts();
    bus.key_in = 1'b1;
    start = cyc + 1;
    run(20);
    checkOutput("hold_steps", steps, 1);
    checkOutput("hold_step_edge", last_step_cyc, start + 6);
    checkOutput("hold_phase", bus.phase, 1);
    checkOutput("hold_key_level", bus.key_level, 1);
    bus.key_in = 1'b0;
    clearCounts();
    run(10);
    checkOutput("release_steps", steps, 0);
    checkOutput("release_key_level", bus.key_level, 0);

    // Bounce 1,0,1,0 then hold.
    clearCounts();
    for (int i = 0; i < 4; i++) begin
      bus.key_in = (i % 2 == 0);
      tick();
    end
    bus.key_in = 1'b1;
    start = cyc + 1;
    run(20);
    checkOutput("bounce_steps", steps, 1);
    checkOutput("bounce_step_edge", last_step_cyc, start + 6);
    checkOutput("bounce_phase", bus.phase, 2);
    bus.key_in = 1'b0;
    run(10);

    // Vector table from a clean reset.
    doReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_steps", i), steps, vecs[i].exp_steps);
      checkOutput($sformatf("vec%0d_done", i), dones, vecs[i].exp_done);
      checkOutput($sformatf("vec%0d_phase", i), bus.phase, vecs[i].exp_phase);
      checkOutput($sformatf("vec%0d_phase_oh", i), bus.phase_oh, vecs[i].exp_oh);
      checkOutput($sformatf("vec%0d_count", i), bus.instr_count, vecs[i].exp_count);
    end

    // 44 clean presses.
    doReset();
    for (int i = 0; i < 44; i++) press(10, 10);
    checkOutput("p44_steps", steps, 44);
    checkOutput("p44_phase", bus.phase, 0);
    checkOutput("p44_count", bus.instr_count, 11);
    checkOutput("p44_done", dones, 11);
    checkOutput("p44_consec", consec, 0);

    // Auto mode: spacing, first-step delay, key presses ignored.
    doReset();
    bus.manual = 1'b0;
    start = cyc + 1;
    n = 0; bad = 0; first = 0; prev = 0;
    for (int i = 0; i < 64; i++) begin
      if (i == 10 || i == 40) bus.key_in = 1'b1;
      if (i == 25 || i == 55) bus.key_in = 1'b0;
      tick();
      if (bus.step) begin
        if (n == 0) first = cyc;
        else if (cyc - prev != 8) bad++;
        prev = cyc;
        n++;
      end
    end
    checkOutput("auto_steps", n, 7);
    checkOutput("auto_first_edge", first, start + 8);
    checkOutput("auto_spacing_bad", bad, 0);
    checkOutput("auto_phase", bus.phase, 3);
    checkOutput("auto_count", bus.instr_count, 1);

    // Halt raised in EX: instruction completes, phase parks at FD.
    waited = 0;
    while (bus.phase != 2'd1 && waited < 64) begin
      tick();
      waited++;
    end
    checkOutput("halt_reach_ex", bus.phase, 1);
    bus.halt = 1'b1;
    c0 = bus.instr_count;
    clearCounts();
    run(48);
    checkOutput("halt_steps", steps, 3);
    checkOutput("halt_phase", bus.phase, 0);
    checkOutput("halt_count", bus.instr_count, c0 + 16'd1);
    checkOutput("halt_done", dones, 1);
    bus.halt = 1'b0;
    lat = 0;
    clearCounts();
    while (steps == 0 && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput("unhalt_latency_ok", (lat >= 1 && lat <= 8), 1);

    // Asynchronous reset in RWB with the key held.
    waited = 0;
    while (bus.phase != 2'd2 && waited < 64) begin
      tick();
      waited++;
    end
    checkOutput("rst_reach_rwb", bus.phase, 2);
    bus.manual = 1'b1;
    bus.key_in = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_phase", bus.phase, 0);
    checkOutput("async_rst_phase_oh", bus.phase_oh, 4'b0001);
    run(3);
    reset_n = 1'b1;
    clearCounts();
    run(30);
    checkOutput("held_after_rst_steps", steps, 0);
    bus.key_in = 1'b0;
    run(10);
    bus.key_in = 1'b1;
    run(12);
    checkOutput("repress_steps", steps, 1);
    checkOutput("repress_phase", bus.phase, 1);
    bus.key_in = 1'b0;
    run(10);

    // Counter wrap from 16'hFFFF.
    doReset();
    for (int i = 0; i < 3; i++) press(10, 10);
    checkOutput("wrap_reach_if", bus.phase, 3);
    force dut.instr_count_q = 16'hFFFF;
    tick();
    release dut.instr_count_q;
    clearCounts();
    press(10, 10);
    checkOutput("wrap_count", bus.instr_count, 16'h0000);
    checkOutput("wrap_done", dones, 1);
    checkOutput("wrap_phase", bus.phase, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
